// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets several byte producers share one uart_tx.
// An owner keeps the transmitter until its packet ends or its burst allowance runs out.
//
// state     | meaning
// IDLE      | no owner; pick the next requester from ptr upward
// GRANT     | owner held; wait for its next byte to be valid
// SEND      | start pulse and accept pulse for the latched byte
// WAIT_BUSY | wait for the transmitter to raise busy (bounded)
// WAIT_DONE | transmitter busy; wait for it to finish the byte
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_busy_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        owner_q;
  logic [7:0]           cnt_q;
  logic                 last_q;
  logic [TW-1:0]        tmo_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [7:0]           tx_data_q;
  logic                 tx_start_q;
  logic                 busy_err_q;

  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        ptr_d;
  logic                 timeout;
  logic                 byte_done;
  logic                 pkt_done;
  logic [7:0]           owner_byte;

  // Lowest offset from ptr wins, so the loop runs downward and the last hit is kept.
  always_comb begin : arb
    logic [IW:0] sum;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      if (req_valid_i[sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[IW-1:0];
      end
    end
  end

  assign pick_oh    = NUM_REQ'(1) << pick_idx;
  assign ptr_d      = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign owner_byte = req_data_i[{owner_q, 3'b000} +: 8];

  // The SEND cycle already counts as one busy-low cycle, hence the <= 1 compare.
  assign timeout   = (state_q == WAIT_BUSY) && !tx_busy_i && (tmo_q <= TW'(1));
  assign byte_done = timeout || ((state_q == WAIT_DONE) && !tx_busy_i);
  assign pkt_done  = last_q || (cnt_q == 8'(MAX_BURST));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      tmo_q       <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      busy_err_q  <= 1'b0;
    end else begin
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            owner_q <= pick_idx;
            grant_q <= pick_oh;
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (req_valid_i[owner_q]) begin
            tx_data_q   <= owner_byte;
            last_q      <= req_last_i[owner_q];
            cnt_q       <= cnt_q + 8'd1;
            tx_start_q  <= 1'b1;
            req_ready_q <= grant_q;
            state_q     <= SEND;
          end
        end
        SEND: begin
          tmo_q   <= TW'(BUSY_TIMEOUT - 1);
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (state_q == WAIT_BUSY && tx_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (byte_done) begin
            if (timeout) begin
              busy_err_q <= 1'b1;
            end
            if (pkt_done) begin
              ptr_q   <= ptr_d;
              grant_q <= '0;
              state_q <= IDLE;
            end else begin
              state_q <= GRANT;
            end
          end else if (state_q == WAIT_BUSY) begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign tx_data_o   = tx_data_q;
  assign tx_start_o  = tx_start_q;
  assign grant_o     = grant_q;
  assign busy_err_o  = busy_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model and
// queue-driven requesters; expected values are hand-computed constants.
module tb_uart_tx_arbiter;
  localparam int NR       = 4;
  localparam int MB       = 4;
  localparam int BT       = 3;
  localparam int BYTE_LEN = 4;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic [NR-1:0]     grant;
  logic              busy_err;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_data_o   (tx_data),
    .tx_start_o  (tx_start),
    .tx_busy_i   (tx_busy),
    .grant_o     (grant),
    .busy_err_o  (busy_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] rq [NR][$];
  logic [7:0] out_d [$];
  logic [3:0] out_r [$];
  logic [3:0] out_g [$];
  int         start_cyc [$];

  int   cyc, n_cmp, n_bad, left;
  bit   busy_on, pend, lock_mon;
  int   busy_fall_cyc, grant_fall_cyc, err_rise_cyc, lock_drop;
  logic [3:0] grant_prev;
  logic err_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        e = rq[i][0];
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i]       = e[8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pend) begin
      tx_busy = 1'b1;
      left    = BYTE_LEN;
      pend    = 1'b0;
    end else if (tx_busy) begin
      left--;
      if (left == 0) begin
        tx_busy       = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
    if (tx_start) begin
      chk("start_while_busy", {31'd0, tx_busy}, 32'd0);
      out_d.push_back(tx_data);
      out_r.push_back(req_ready);
      out_g.push_back(grant);
      start_cyc.push_back(cyc);
      if (busy_on) pend = 1'b1;
    end
    if (grant_prev != 4'd0 && grant == 4'd0) grant_fall_cyc = cyc;
    grant_prev = grant;
    if (!err_prev && busy_err) err_rise_cyc = cyc;
    err_prev = busy_err;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    if (lock_mon && rq[0].size() > 0 && rq[0].size() < 3 && grant !== 4'b0001) lock_drop++;
    drive();
  endtask

  function automatic bit all_idle();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) e = 1'b0;
    return e && grant == 4'd0 && !tx_busy && !pend;
  endfunction

  task automatic run_idle(input string tag, input int maxc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!all_idle() && n < maxc);
    chk({tag, "_done"}, {31'd0, all_idle()}, 32'd1);
  endtask

  task automatic clear_logs();
    out_d.delete();
    out_r.delete();
    out_g.delete();
    start_cyc.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) rq[i].delete();
    tx_busy = 1'b0;
    pend    = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    grant_prev = '0;
    err_prev   = 1'b0;
  endtask

  function automatic logic [7:0] od(input int i);
    return (i < out_d.size()) ? out_d[i] : 8'hxx;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    n_cmp = 0; n_bad = 0; cyc = 0; left = 0;
    busy_on = 1'b1; pend = 1'b0; lock_mon = 1'b0; lock_drop = 0;
    busy_fall_cyc = 0; grant_fall_cyc = 0; err_rise_cyc = 0;
    rst_n = 1'b0; tx_busy = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_err", {31'd0, busy_err}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    do_reset();

    // Single byte
    clear_logs();
    rq[0].push_back({1'b1, 8'h41});
    drive();
    c0 = cyc;
    run_idle("single", 40);
    chk("single_count", out_d.size(), 32'd1);
    chk("single_data", {24'd0, od(0)}, 32'h41);
    chk("single_ready", {28'd0, out_r[0]}, 32'h1);
    chk("single_latency", start_cyc[0] - c0, 32'd2);
    chk("single_grant_drop", grant_fall_cyc - busy_fall_cyc, 32'd1);

    // Round robin
    do_reset();
    clear_logs();
    for (int i = 0; i < NR; i++) rq[i].push_back({1'b1, 8'(8'h10 + i)});
    drive();
    run_idle("rr4", 200);
    chk("rr_d0", {24'd0, od(0)}, 32'h10);
    chk("rr_d1", {24'd0, od(1)}, 32'h11);
    chk("rr_d2", {24'd0, od(2)}, 32'h12);
    chk("rr_d3", {24'd0, od(3)}, 32'h13);
    chk("rr_ready3", {28'd0, out_r[3]}, 32'h8);
    clear_logs();
    rq[3].push_back({1'b1, 8'h23});
    rq[1].push_back({1'b1, 8'h21});
    drive();
    run_idle("rr2", 100);
    chk("rr2_d0", {24'd0, od(0)}, 32'h21);
    chk("rr2_d1", {24'd0, od(1)}, 32'h23);

    // Packet lock
    clear_logs();
    rq[0].push_back({1'b0, 8'hA0});
    rq[0].push_back({1'b0, 8'hA1});
    rq[0].push_back({1'b1, 8'hA2});
    rq[1].push_back({1'b1, 8'hB0});
    drive();
    lock_mon = 1'b1;
    lock_drop = 0;
    run_idle("lock", 200);
    lock_mon = 1'b0;
    chk("lock_count", out_d.size(), 32'd4);
    chk("lock_d1", {24'd0, od(1)}, 32'hA1);
    chk("lock_d2", {24'd0, od(2)}, 32'hA2);
    chk("lock_d3", {24'd0, od(3)}, 32'hB0);
    chk("lock_grant2", {28'd0, out_g[2]}, 32'h1);
    chk("lock_grant3", {28'd0, out_g[3]}, 32'h2);
    chk("lock_held", lock_drop, 32'd0);

    // Burst limit
    clear_logs();
    for (int i = 0; i < 20; i++) rq[0].push_back({1'b0, 8'(i)});
    rq[1].push_back({1'b1, 8'h55});
    drive();
    run_idle("burst", 600);
    chk("burst_count", out_d.size(), 32'd21);
    chk("burst_d3", {24'd0, od(3)}, 32'h03);
    chk("burst_d4", {24'd0, od(4)}, 32'h55);
    chk("burst_d5", {24'd0, od(5)}, 32'h04);
    chk("burst_d20", {24'd0, od(20)}, 32'h13);

    // Busy timeout
    clear_logs();
    busy_on = 1'b0;
    chk("tmo_err_before", {31'd0, busy_err}, 32'd0);
    rq[0].push_back({1'b0, 8'hC0});
    rq[0].push_back({1'b1, 8'hC1});
    drive();
    run_idle("tmo", 100);
    chk("tmo_count", out_d.size(), 32'd2);
    chk("tmo_d1", {24'd0, od(1)}, 32'hC1);
    chk("tmo_err_rise", err_rise_cyc - start_cyc[0], 32'd3);
    chk("tmo_next_start", start_cyc[1] - start_cyc[0], 32'd4);
    chk("tmo_err_sticky", {31'd0, busy_err}, 32'd1);
    busy_on = 1'b1;

    // Reset mid-transfer; move ptr to 2 first so the reset clear is visible
    clear_logs();
    rq[1].push_back({1'b1, 8'hF1});
    drive();
    run_idle("pre_rst", 40);
    rq[3].push_back({1'b1, 8'hD3});
    drive();
    for (int n = 0; n < 20 && !tx_busy; n++) step();
    step();
    step();
    chk("mid_busy", {31'd0, tx_busy}, 32'd1);
    chk("mid_grant", {28'd0, grant}, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_start", {31'd0, tx_start}, 32'd0);
    chk("arst_ready", {28'd0, req_ready}, 32'd0);
    chk("arst_err", {31'd0, busy_err}, 32'd0);
    chk("arst_data", {24'd0, tx_data}, 32'd0);
    do_reset();
    clear_logs();
    rq[2].push_back({1'b1, 8'hE2});
    rq[1].push_back({1'b1, 8'hE1});
    drive();
    run_idle("post_rst", 100);
    chk("post_rst_d0", {24'd0, od(0)}, 32'hE1);
    chk("post_rst_d1", {24'd0, od(1)}, 32'hE2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
